// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the requesting ports, the arbiter and the memory.
// The arbiter uses the slave view. The port/memory environment uses the master view.
interface mem_port_arbiter_if #(
    parameter int NPORTS = 4,
    parameter int AW     = 22
);
    logic [NPORTS-1:0]    read_request;
    logic [NPORTS-1:0]    write_request;
    logic [NPORTS*AW-1:0] port_addr;
    logic [NPORTS*32-1:0] port_wdata;
    logic [NPORTS-1:0]    grant;
    logic [NPORTS-1:0]    port_ready;
    logic                 mem_rd;
    logic                 mem_wr;
    logic [AW-1:0]        mem_addr;
    logic [31:0]          mem_wdata;
    logic                 mem_done;
    logic                 timeout_err;

    modport slave (
        input  read_request, write_request, port_addr, port_wdata, mem_done,
        output grant, port_ready, mem_rd, mem_wr, mem_addr, mem_wdata, timeout_err
    );

    modport master (
        output read_request, write_request, port_addr, port_wdata, mem_done,
        input  grant, port_ready, mem_rd, mem_wr, mem_addr, mem_wdata, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates NPORTS request ports onto one memory port, using fixed-priority or round-robin selection.
// A grant tenure allows bounded bursts. A BUSY watchdog aborts a transfer when memory does not answer.
module mem_port_arbiter #(
    parameter int NPORTS    = 4,
    parameter int AW        = 22,
    parameter int RR_MODE   = 0,
    parameter int BURST_MAX = 4,
    parameter int TIMEOUT   = 255
) (
    input logic                 clk,
    input logic                 rst_n,
    mem_port_arbiter_if.slave   bus
);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_e;

    state_e            state_q;
    logic [NPORTS-1:0] grant_q;
    logic [NPORTS-1:0] ready_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic              timeout_err_q;
    logic [3:0]        beat_q;
    logic [7:0]        tmo_q;
    logic [PW-1:0]     rr_ptr_q;
    logic [PW-1:0]     win_q;

    logic [NPORTS-1:0] req;
    logic [PW-1:0]     pick;
    logic [PW-1:0]     win_next;
    logic              win_req;
    logic              win_wr;
    logic [AW-1:0]     mux_addr;
    logic [31:0]       mux_wdata;

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned (no latch).
    always_comb begin
        req  = bus.read_request | bus.write_request;
        pick = '0;
        if (RR_MODE != 0) begin
            // Walk downward so that the requester closest at or above rr_ptr is assigned last.
            for (int k = NPORTS - 1; k >= 0; k--) begin
                if (req[(int'(rr_ptr_q) + k) % NPORTS]) pick = PW'((int'(rr_ptr_q) + k) % NPORTS);
            end
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (req[i]) pick = PW'(i);
            end
        end
    end

    always_comb begin
        win_next = (int'(win_q) == NPORTS - 1) ? '0 : win_q + PW'(1);
        win_req  = req[win_q];
        win_wr   = bus.write_request[win_q];
    end

    always_comb begin
        mux_addr  = '0;
        mux_wdata = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant_q[i]) begin
                mux_addr  = mux_addr  | bus.port_addr[i*AW +: AW];
                mux_wdata = mux_wdata | bus.port_wdata[i*32 +: 32];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            ready_q       <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            beat_q        <= '0;
            tmo_q         <= '0;
            rr_ptr_q      <= '0;
            win_q         <= '0;
        end else begin
            ready_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_q  <= NPORTS'(1) << pick;
                        win_q    <= pick;
                        mem_wr_q <= bus.write_request[pick];
                        mem_rd_q <= !bus.write_request[pick];
                        beat_q   <= '0;
                        tmo_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_done) begin
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        ready_q  <= grant_q;
                        beat_q   <= beat_q + 4'd1;
                        state_q  <= GAP;
                    end else if (tmo_q == TMO_LAST) begin
                        mem_rd_q      <= 1'b0;
                        mem_wr_q      <= 1'b0;
                        timeout_err_q <= 1'b1;
                        grant_q       <= '0;
                        rr_ptr_q      <= win_next;
                        state_q       <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                GAP: begin
                    if (win_req && (beat_q < BURST_LIM)) begin
                        mem_wr_q <= win_wr;
                        mem_rd_q <= !win_wr;
                        tmo_q    <= '0;
                        state_q  <= BUSY;
                    end else begin
                        grant_q  <= '0;
                        rr_ptr_q <= win_next;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.port_ready  = ready_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_addr    = mux_addr;
    assign bus.mem_wdata   = mux_wdata;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. dut_a runs fixed priority (burst 4, timeout 8).
// dut_b runs round-robin (burst 1, timeout 8).
module tb_mem_port_arbiter;
    localparam int NP = 4;
    localparam int AW = 22;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.NPORTS(NP), .AW(AW)) ifa ();
    mem_port_arbiter_if #(.NPORTS(NP), .AW(AW)) ifb ();

    mem_port_arbiter #(.NPORTS(NP), .AW(AW), .RR_MODE(0), .BURST_MAX(4), .TIMEOUT(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    mem_port_arbiter #(.NPORTS(NP), .AW(AW), .RR_MODE(1), .BURST_MAX(1), .TIMEOUT(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] rd;
        logic [3:0] wr;
        logic       done;
        logic [3:0] g;
        logic [3:0] rdy;
        logic       mrd;
        logic       mwr;
        int         mux;
    } vec_t;

    vec_t        vq[$];
    logic [21:0] addr_c[NP];
    logic [31:0] wd_c[NP];
    int          checks = 0;
    int          errors = 0;
    int          cnt_a  = 0;
    int          cnt_b  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic [3:0] rd, input logic [3:0] wr, input logic d,
                       input logic [3:0] g, input logic [3:0] rdy, input logic mrd, input logic mwr,
                       input int mux);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.done = d; v.g = g; v.rdy = rdy;
        v.mrd = mrd; v.mwr = mwr; v.mux = mux;
        vq.push_back(v);
    endtask

    function automatic logic [21:0] exp_addr(input int m);
        return (m < 0) ? 22'h0 : addr_c[m];
    endfunction

    function automatic logic [31:0] exp_wdata(input int m);
        return (m < 0) ? 32'h0 : wd_c[m];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model: mem_done is pulsed on the second BUSY cycle of each strobe.
    task automatic mem_a();
        step();
        if (ifa.mem_done) begin
            ifa.mem_done = 1'b0;
            cnt_a = 0;
        end else if (ifa.mem_rd || ifa.mem_wr) begin
            cnt_a++;
            if (cnt_a == 2) ifa.mem_done = 1'b1;
        end
    endtask

    task automatic mem_b();
        step();
        if (ifb.mem_done) begin
            ifb.mem_done = 1'b0;
            cnt_b = 0;
        end else if (ifb.mem_rd || ifb.mem_wr) begin
            cnt_b++;
            if (cnt_b == 2) ifb.mem_done = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p1;
        int p3;
        int busy;
        int n;
        logic seen;
        logic rs;
        logic overlap_bad;
        logic noidle_bad;
        logic [3:0] prev;
        int order[5];
        int exp_order[5];

        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NP; i++) begin
            addr_c[i] = 22'h2A0000 | 22'(i * 'h1111);
            wd_c[i]   = 32'h1000_0000 + 32'(i);
        end
        wd_c[2] = 32'hDEADBEEF;

        rst_n = 1'b0;
        ifa.read_request = '0; ifa.write_request = '0; ifa.mem_done = 1'b0;
        ifb.read_request = '0; ifb.write_request = '0; ifb.mem_done = 1'b0;
        for (int i = 0; i < NP; i++) begin
            ifa.port_addr[i*AW +: AW]  = addr_c[i];
            ifb.port_addr[i*AW +: AW]  = addr_c[i];
            ifa.port_wdata[i*32 +: 32] = wd_c[i];
            ifb.port_wdata[i*32 +: 32] = wd_c[i];
        end

        #12;
        check("rst_grant", 64'(ifa.grant), 64'h0);
        check("rst_ready", 64'(ifa.port_ready), 64'h0);
        check("rst_strobes", 64'({ifa.mem_rd, ifa.mem_wr}), 64'h0);
        check("rst_err", 64'(ifa.timeout_err), 64'h0);
        check("rst_addr", 64'(ifa.mem_addr), 64'h0);
        check("rst_grant_b", 64'(ifb.grant), 64'h0);
        rst_n = 1'b1;

        // name, rd, wr, done, exp grant, exp ready, exp rd, exp wr, muxed port
        add("fp_pick2",     4'b0110, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0,  2);
        add("busy_hold1",   4'b0110, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0,  2);
        add("busy_hold2",   4'b0110, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0,  2);
        add("done_ready2",  4'b0110, 4'b0000, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0,  2);
        add("gap_release",  4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, -1);
        add("idle_pick1",   4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0,  1);
        add("drop_in_busy", 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0010, 1'b0, 1'b0,  1);
        add("done_in_gap",  4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, -1);
        add("wr_wins",      4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1,  2);
        add("wr_done",      4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0,  2);
        add("gap_end_wr",   4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, -1);
        add("done_in_idle", 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, -1);
        add("fp_pick3",     4'b1001, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0,  3);
        add("done3",        4'b0001, 4'b0000, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0,  3);
        add("gap_end3",     4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, -1);
        add("pick0",        4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0,  0);
        add("done0",        4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0,  0);
        add("gap_end0",     4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, -1);

        foreach (vq[i]) begin
            ifa.read_request  = vq[i].rd;
            ifa.write_request = vq[i].wr;
            ifa.mem_done      = vq[i].done;
            step();
            check({vq[i].name, "_grant"}, 64'(ifa.grant), 64'(vq[i].g));
            check({vq[i].name, "_ready"}, 64'(ifa.port_ready), 64'(vq[i].rdy));
            check({vq[i].name, "_rd"}, 64'(ifa.mem_rd), 64'(vq[i].mrd));
            check({vq[i].name, "_wr"}, 64'(ifa.mem_wr), 64'(vq[i].mwr));
            check({vq[i].name, "_addr"}, 64'(ifa.mem_addr), 64'(exp_addr(vq[i].mux)));
            check({vq[i].name, "_wdata"}, 64'(ifa.mem_wdata), 64'(exp_wdata(vq[i].mux)));
            check({vq[i].name, "_err"}, 64'(ifa.timeout_err), 64'h0);
        end
        ifa.read_request = '0; ifa.write_request = '0; ifa.mem_done = 1'b0;

        // Burst limit: port1 keeps requesting, port3 joins once port1 holds the grant.
        cnt_a = 0;
        p1 = 0; p3 = 0; seen = 1'b0; overlap_bad = 1'b0;
        ifa.read_request = 4'b0010;
        mem_a();
        check("burst_first_grant", 64'(ifa.grant), 64'h2);
        ifa.read_request = 4'b1010;
        for (int k = 0; k < 80; k++) begin
            mem_a();
            if (!$onehot0(ifa.grant)) overlap_bad = 1'b1;
            if (ifa.port_ready[1]) p1++;
            if (ifa.grant == 4'b1000) begin
                seen = 1'b1;
                break;
            end
        end
        check("burst_p1_ready_count", 64'(p1), 64'd4);
        check("burst_then_p3", 64'(seen), 64'h1);
        check("burst_onehot", 64'(overlap_bad), 64'h0);
        ifa.read_request = '0;
        for (int k = 0; k < 20; k++) begin
            mem_a();
            if (ifa.port_ready[3]) p3 = 1;
            if (ifa.grant == 4'b0000 && p3 == 1) break;
        end
        check("burst_p3_done", 64'(p3), 64'h1);

        // Watchdog abort with mem_done withheld.
        ifa.mem_done = 1'b0; cnt_a = 0;
        check("err_before_to", 64'(ifa.timeout_err), 64'h0);
        busy = 0; rs = 1'b0;
        ifa.read_request = 4'b0001;
        step();
        for (int k = 0; k < 20; k++) begin
            if (ifa.port_ready != 0) rs = 1'b1;
            if (ifa.grant == 4'b0000) break;
            if (ifa.mem_rd) busy++;
            step();
        end
        ifa.read_request = '0;
        check("to_busy_cycles", 64'(busy), 64'd8);
        check("to_err_set", 64'(ifa.timeout_err), 64'h1);
        check("to_grant_zero", 64'(ifa.grant), 64'h0);
        check("to_rd_low", 64'(ifa.mem_rd), 64'h0);
        check("to_no_ready", 64'(rs), 64'h0);
        step();
        ifa.read_request = 4'b0100;
        step();
        check("after_to_grant", 64'(ifa.grant), 64'h4);
        ifa.read_request = '0;
        ifa.mem_done = 1'b1;
        step();
        ifa.mem_done = 1'b0;
        check("after_to_ready", 64'(ifa.port_ready), 64'h4);
        check("err_sticky", 64'(ifa.timeout_err), 64'h1);
        step();
        check("after_to_idle", 64'(ifa.grant), 64'h0);

        // Round-robin rotation with all four ports requesting continuously.
        cnt_b = 0; n = 0; prev = '0; overlap_bad = 1'b0; noidle_bad = 1'b0;
        order = '{-1, -1, -1, -1, -1};
        ifb.read_request = 4'b1111;
        for (int k = 0; k < 80; k++) begin
            mem_b();
            if (!$onehot0(ifb.grant)) overlap_bad = 1'b1;
            if (ifb.grant != 0 && ifb.grant != prev) begin
                if (prev != 0) noidle_bad = 1'b1;
                for (int j = 0; j < NP; j++) begin
                    if (ifb.grant[j] && n < 5) order[n] = j;
                end
                n++;
            end
            prev = ifb.grant;
            if (n >= 5) break;
        end
        ifb.read_request = '0;
        for (int k = 0; k < 15; k++) mem_b();
        ifb.mem_done = 1'b0;
        check("rr_tenures", 64'(n), 64'd5);
        for (int j = 0; j < 5; j++) check($sformatf("rr_order%0d", j), 64'(order[j]), 64'(exp_order[j]));
        check("rr_onehot", 64'(overlap_bad), 64'h0);
        check("rr_idle_gap", 64'(noidle_bad), 64'h0);
        check("rr_drained", 64'(ifb.grant), 64'h0);

        // Asynchronous reset in the middle of BUSY.
        ifa.read_request = 4'b0001;
        ifb.read_request = 4'b0100;
        step();
        check("pre_rst_grant_a", 64'(ifa.grant), 64'h1);
        check("pre_rst_grant_b", 64'(ifb.grant), 64'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_grant_a", 64'(ifa.grant), 64'h0);
        check("arst_rd_a", 64'(ifa.mem_rd), 64'h0);
        check("arst_ready_a", 64'(ifa.port_ready), 64'h0);
        check("arst_err_a", 64'(ifa.timeout_err), 64'h0);
        check("arst_grant_b", 64'(ifb.grant), 64'h0);
        check("arst_rd_b", 64'(ifb.mem_rd), 64'h0);
        ifa.read_request = 4'b1001;
        ifb.read_request = 4'b1001;
        step();
        check("rst_held_grant_b", 64'(ifb.grant), 64'h0);
        #3;
        rst_n = 1'b1;
        step();
        check("post_rst_rr_grant", 64'(ifb.grant), 64'h1);
        check("post_rst_fp_grant", 64'(ifa.grant), 64'h8);
        check("post_rst_no_ready", 64'(ifa.port_ready | ifb.port_ready), 64'h0);
        check("post_rst_err", 64'(ifa.timeout_err), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
